down_counter_ctrl: RTL and testbench

Controller that sequences a synchronous down counter for timing and event-spacing jobs. It loads a start value and counts to zero, then either stops (one-shot) or reloads (auto-reload). It supports pause and abort, and reports terminal-count and completion pulses. The counter datapath is instantiated inside; the FSM gates its load and enable.

---
 rtl/counter_ctrl_pkg.sv | 14 +
 rtl/sync_down_counter.sv | 27 ++
 rtl/down_counter_ctrl.sv | 126 ++++++++++++
 tb/tb_down_counter_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared types for the down-counter controller.
// State codes are fixed because they are exported on the debug port.
package counter_ctrl_pkg;

  localparam int CNT_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/sync_down_counter.sv
// Synchronous down counter with load and count enable.
// Load wins over enable; the count saturates at zero.
module sync_down_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             zero
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (en && (q != '0)) begin
      q <= q - 1'b1;
    end
  end

  assign zero = (q == '0);

endmodule

// File: rtl/down_counter_ctrl.sv
// Sequencer for a down counter: one-shot or auto-reload,
// with pause, abort, terminal-count and completion pulses.
module down_counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             tc,
  output logic             done,
  output logic [1:0]       state
);

  state_t           st;
  state_t           nxt;
  logic [WIDTH-1:0] reload_reg;
  logic             mode;

  logic             cnt_load;
  logic             cnt_en;
  logic [WIDTH-1:0] cnt_d;
  logic             zero;

  logic             capture;
  logic             tc_n;
  logic             done_n;
  logic             busy_n;

  sync_down_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk  (clk),
    .reset(reset),
    .load (cnt_load),
    .en   (cnt_en),
    .d    (cnt_d),
    .q    (q),
    .zero (zero)
  );

  always_comb begin
    nxt      = st;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_d    = '0;
    capture  = 1'b0;
    tc_n     = 1'b0;
    done_n   = 1'b0;
    unique case (st)
      IDLE: begin
        if (start && !stop) begin
          capture  = 1'b1;
          cnt_load = 1'b1;
          cnt_d    = load_val;
          nxt      = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          // abort clears the count via a zero load
          cnt_load = 1'b1;
          cnt_d    = '0;
          nxt      = IDLE;
        end else if (pause) begin
          nxt = HOLD;
        end else if (!zero) begin
          cnt_en = 1'b1;
        end else begin
          tc_n = 1'b1;
          if (mode) begin
            cnt_load = 1'b1;
            cnt_d    = reload_reg;
          end else begin
            done_n = 1'b1;
            nxt    = DONE;
          end
        end
      end
      HOLD: begin
        if (stop) begin
          cnt_load = 1'b1;
          cnt_d    = '0;
          nxt      = IDLE;
        end else if (!pause) begin
          nxt = RUN;
        end
      end
      DONE: begin
        nxt = IDLE;
      end
    endcase
  end

  assign busy_n = (nxt == RUN) || (nxt == HOLD);

  always_ff @(posedge clk) begin
    if (reset) begin
      st         <= IDLE;
      reload_reg <= '0;
      mode       <= 1'b0;
      busy       <= 1'b0;
      tc         <= 1'b0;
      done       <= 1'b0;
    end else begin
      st   <= nxt;
      busy <= busy_n;
      tc   <= tc_n;
      done <= done_n;
      if (capture) begin
        reload_reg <= load_val;
        mode       <= auto_reload;
      end
    end
  end

  assign state = st;

endmodule

// File: tb/tb_down_counter_ctrl.sv
// Directed bench for down_counter_ctrl with a cycle model
// and hand-computed literal expectations.
module tb_down_counter_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic       auto_reload = 1'b0;
  logic [2:0] load_val = 3'd0;
  logic [2:0] q;
  logic       busy;
  logic       tc;
  logic       done;
  logic [1:0] state;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  down_counter_ctrl #(.WIDTH(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .pause      (pause),
    .auto_reload(auto_reload),
    .load_val   (load_val),
    .q          (q),
    .busy       (busy),
    .tc         (tc),
    .done       (done),
    .state      (state)
  );

  always #5 clk = ~clk;

  // model: phase 0 idle, 1 counting, 2 held, 3 finished
  int m_ph = 0;
  int m_q = 0;
  int m_rl = 0;
  int m_auto = 0;
  int m_tc = 0;
  int m_done = 0;

  always @(posedge clk) begin
    int ntc, ndone;
    ntc = 0;
    ndone = 0;
    if (reset) begin
      m_ph = 0; m_q = 0; m_rl = 0; m_auto = 0;
    end else if (m_ph == 0) begin
      if (start && !stop) begin
        m_q = load_val; m_rl = load_val;
        m_auto = auto_reload; m_ph = 1;
      end
    end else if (m_ph == 3) begin
      m_ph = 0;
    end else if (stop) begin
      m_q = 0; m_ph = 0;
    end else if (m_ph == 2) begin
      if (!pause) m_ph = 1;
    end else if (pause) begin
      m_ph = 2;
    end else if (m_q > 0) begin
      m_q = m_q - 1;
    end else begin
      ntc = 1;
      if (m_auto != 0) m_q = m_rl;
      else begin ndone = 1; m_ph = 3; end
    end
    m_tc = ntc;
    m_done = ndone;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_q", int'(q), m_q);
      chk("model_state", int'(state), m_ph);
      chk("model_busy", int'(busy), int'(m_ph == 1 || m_ph == 2));
      chk("model_tc", int'(tc), m_tc);
      chk("model_done", int'(done), m_done);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int v, input bit ar);
    load_val = 3'(v);
    auto_reload = ar;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
    $fatal(1);
  end

  initial begin
    int ntc;
    reset = 1'b1;
    tick();
    tick();
    chk("rst_q", q, 0);
    chk("rst_state", state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tcdone", {tc, done}, 0);
    reset = 1'b0;
    cmp_en = 1'b1;

    // one-shot 3
    go(3, 1'b0);
    chk("os_q3", q, 3);
    chk("os_busy", busy, 1);
    tick(); chk("os_q2", q, 2);
    tick(); chk("os_q1", q, 1);
    tick(); chk("os_q0", q, 0);
    chk("os_tc_early", tc, 0);
    tick();
    chk("os_tc", tc, 1);
    chk("os_done", done, 1);
    chk("os_state_done", state, 3);
    chk("os_busy_done", busy, 0);
    tick();
    chk("os_idle", state, 0);
    chk("os_idle_q", q, 0);
    chk("os_idle_pulses", {tc, done}, 0);

    // auto-reload 7
    go(7, 1'b1);
    chk("ar_q7", q, 7);
    ntc = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("ar_q", q, 7 - (k % 8));
      chk("ar_tc", tc, int'(k % 8 == 0));
      chk("ar_done", done, 0);
      chk("ar_busy", busy, 1);
      ntc += int'(tc);
    end
    chk("ar_tc_count", ntc, 2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("ar_stop_q", q, 0);
    chk("ar_stop_state", state, 0);

    // pause, start while running, stop in hold
    go(6, 1'b0);
    tick();
    tick();
    chk("pz_q4", q, 4);
    pause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("pz_hold", state, 2);
      chk("pz_hold_q", q, 4);
      chk("pz_busy", busy, 1);
    end
    pause = 1'b0;
    tick();
    chk("pz_run", state, 1);
    chk("pz_run_q", q, 4);
    tick();
    chk("pz_q3", q, 3);
    load_val = 3'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("pz_start_ign", q, 2);
    pause = 1'b1;
    tick();
    chk("pz_hold2", state, 2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    pause = 1'b0;
    chk("st_q", q, 0);
    chk("st_state", state, 0);
    chk("st_busy", busy, 0);
    chk("st_tc", tc, 0);

    // start and stop together in idle
    load_val = 3'd5;
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    chk("ss_state", state, 0);
    chk("ss_busy", busy, 0);

    // reset mid-run
    go(5, 1'b0);
    tick(); tick(); tick();
    chk("rr_q2", q, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rr_q", q, 0);
    chk("rr_state", state, 0);
    chk("rr_outs", {busy, tc, done}, 0);
    go(4, 1'b0);
    chk("rr_q4", q, 4);
    tick();
    chk("rr_q3", q, 3);
    for (int k = 0; k < 6; k++) tick();
    chk("rr_idle", state, 0);

    // zero load, auto-reload then one-shot
    go(0, 1'b1);
    chk("z_q", q, 0);
    chk("z_state", state, 1);
    chk("z_tc0", tc, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("z_tc", tc, 1);
      chk("z_run", state, 1);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    go(0, 1'b0);
    chk("zo_q", q, 0);
    tick();
    chk("zo_tcdone", {tc, done}, 3);
    chk("zo_state", state, 3);
    tick();
    chk("zo_idle", state, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
